load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 160 ++++++++++++++++
 tb/tb_load_store_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit bridging the CPU MEM stage to a simple req/ack bus.
// Accepts one aligned access, holds the bus request until ack or timeout, then returns extended load data.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic        mem_wr_en,
    input  logic [2:0]  mem_op,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_data_in,
    output logic [31:0] mem_data_out,
    output logic        stall,
    output logic        access_fault,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic        r_req;
    logic        r_we;
    logic [2:0]  r_op;
    logic [1:0]  r_lo;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [31:0] r_dout;
    logic        r_err;

    logic        w_legal_op;
    logic        w_misalign;
    logic        w_idle;
    logic        w_accept;
    logic        w_fault;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shift;
    logic [31:0] w_load;

    always_comb begin
        w_legal_op = (mem_op == 3'b000) || (mem_op == 3'b001) || (mem_op == 3'b010) ||
                     (mem_op == 3'b100) || (mem_op == 3'b101);
        w_misalign = ((mem_op[1:0] == 2'b01) && mem_addr[0]) ||
                     ((mem_op[1:0] == 2'b10) && (mem_addr[1:0] != 2'b00));
        w_idle     = (r_state == S_IDLE);
        w_accept   = resetn && w_idle && req_valid && w_legal_op && !w_misalign;
        w_fault    = resetn && w_idle && req_valid && !(w_legal_op && !w_misalign);
    end

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = mem_data_in;
        case (mem_op[1:0])
            2'b00: begin
                w_be    = 4'b0001 << mem_addr[1:0];
                w_wdata = {4{mem_data_in[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << {mem_addr[1], 1'b0};
                w_wdata = {2{mem_data_in[15:0]}};
            end
            default: ;
        endcase
    end

    // Halfwords are always half-aligned, so the byte-lane shift also serves them.
    always_comb begin
        w_shift = bus_rdata >> {r_lo, 3'b000};
        case (r_op)
            3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b100:  w_load = {24'd0, w_shift[7:0]};
            3'b101:  w_load = {16'd0, w_shift[15:0]};
            default: w_load = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_op    <= 3'b000;
            r_lo    <= 2'b00;
            r_addr  <= 32'd0;
            r_be    <= 4'd0;
            r_wdata <= 32'd0;
            r_dout  <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_err <= 1'b0;
                    if (w_accept) begin
                        r_state <= S_BUSY;
                        r_cnt   <= 8'd0;
                        r_req   <= 1'b1;
                        r_we    <= mem_wr_en;
                        r_op    <= mem_op;
                        r_lo    <= mem_addr[1:0];
                        r_addr  <= {mem_addr[31:2], 2'b00};
                        r_be    <= w_be;
                        r_wdata <= w_wdata;
                    end else if (w_fault) begin
                        r_dout <= 32'd0;
                    end
                end
                S_BUSY: begin
                    // Ack takes priority over a timeout landing in the same cycle.
                    if (bus_ack) begin
                        r_state <= S_DONE;
                        r_req   <= 1'b0;
                        r_dout  <= r_we ? 32'd0 : w_load;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= S_DONE;
                        r_req   <= 1'b0;
                        r_err   <= 1'b1;
                        r_dout  <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    assign stall        = w_accept || (r_state == S_BUSY);
    assign access_fault = w_fault;
    assign bus_err      = r_err;
    assign bus_req      = r_req;
    assign bus_we       = r_we;
    assign bus_addr     = r_addr;
    assign bus_be       = r_be;
    assign bus_wdata    = r_wdata;
    assign mem_data_out = w_fault ? 32'd0 : r_dout;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: table of single transactions plus timeout, ack/timeout tie and reset-in-busy sequences.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        mem_wr_en = 1'b0;
    logic [2:0]  mem_op = 3'b000;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_data_in = 32'd0;
    logic [31:0] mem_data_out;
    logic        stall;
    logic        access_fault;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'd0;

    int checks = 0;
    int errors = 0;
    logic [31:0] mem [64];

    load_store_unit #(.TIMEOUT(16)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .mem_wr_en(mem_wr_en),
        .mem_op(mem_op), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out), .stall(stall), .access_fault(access_fault),
        .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] din;
        logic        fault;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] dout;
    } vec_t;

    vec_t vecs [19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_req(input logic we, input logic [2:0] op, input logic [31:0] addr, input logic [31:0] din);
        req_valid   = 1'b1;
        mem_wr_en   = we;
        mem_op      = op;
        mem_addr    = addr;
        mem_data_in = din;
    endtask

    // Bus slave: respond from the small word memory, apply byte-enabled writes.
    task automatic slave_ack();
        bus_ack   = 1'b1;
        bus_rdata = bus_we ? 32'hDEADBEEF : mem[bus_addr[7:2]];
        if (bus_we)
            for (int b = 0; b < 4; b++)
                if (bus_be[b]) mem[bus_addr[7:2]][8*b +: 8] = bus_wdata[8*b +: 8];
    endtask

    task automatic do_txn(input vec_t v, input int idx);
        drive_req(v.we, v.op, v.addr, v.din);
        #1;
        if (v.fault) begin
            chk($sformatf("v%0d fault_pulse", idx), access_fault, 1);
            chk($sformatf("v%0d fault_stall", idx), stall, 0);
            chk($sformatf("v%0d fault_dout", idx), mem_data_out, 0);
            cycle();
            req_valid = 1'b0;
            #1;
            chk($sformatf("v%0d fault_busreq", idx), bus_req, 0);
            chk($sformatf("v%0d fault_oneshot", idx), access_fault, 0);
            chk($sformatf("v%0d fault_stall2", idx), stall, 0);
        end else begin
            chk($sformatf("v%0d req_stall", idx), stall, 1);
            chk($sformatf("v%0d req_nofault", idx), access_fault, 0);
            cycle();
            chk($sformatf("v%0d busy_req", idx), bus_req, 1);
            chk($sformatf("v%0d busy_stall", idx), stall, 1);
            chk($sformatf("v%0d busy_we", idx), bus_we, v.we);
            chk($sformatf("v%0d busy_addr", idx), bus_addr, {v.addr[31:2], 2'b00});
            chk($sformatf("v%0d busy_be", idx), bus_be, v.be);
            if (v.we) chk($sformatf("v%0d busy_wdata", idx), bus_wdata, v.wdata);
            slave_ack();
            cycle();
            bus_ack   = 1'b0;
            req_valid = 1'b0;
            #1;
            chk($sformatf("v%0d done_stall", idx), stall, 0);
            chk($sformatf("v%0d done_busreq", idx), bus_req, 0);
            chk($sformatf("v%0d done_buserr", idx), bus_err, 0);
            chk($sformatf("v%0d done_dout", idx), mem_data_out, v.dout);
            cycle();
            chk($sformatf("v%0d idle_hold", idx), mem_data_out, v.dout);
        end
    endtask

    // Issue an aligned LW and count BUSY cycles; ack on BUSY cycle ack_at (0 = never).
    task automatic busy_run(input logic [31:0] addr, input int ack_at, output int n, output logic stable);
        logic [31:0] sa;
        logic [3:0]  sb;
        drive_req(1'b0, 3'b010, addr, 32'd0);
        cycle();
        n = 0;
        stable = 1'b1;
        sa = bus_addr;
        sb = bus_be;
        while (bus_req && n < 40) begin
            n++;
            if (bus_addr !== sa || bus_be !== sb || stall !== 1'b1) stable = 1'b0;
            bus_ack   = (n == ack_at);
            bus_rdata = mem[addr[7:2]];
            cycle();
        end
        bus_ack   = 1'b0;
        req_valid = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic st;
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        //            we    op      addr          din            flt   be     wdata          dout
        vecs[0]  = '{1'b1, 3'b010, 32'h100, 32'h12345678, 1'b0, 4'hF, 32'h12345678, 32'h0};
        vecs[1]  = '{1'b0, 3'b010, 32'h100, 32'h0,        1'b0, 4'hF, 32'h0,        32'h12345678};
        vecs[2]  = '{1'b0, 3'b000, 32'h101, 32'h0,        1'b0, 4'h2, 32'h0,        32'h00000056};
        vecs[3]  = '{1'b0, 3'b001, 32'h102, 32'h0,        1'b0, 4'hC, 32'h0,        32'h00001234};
        vecs[4]  = '{1'b0, 3'b010, 32'h102, 32'h0,        1'b1, 4'h0, 32'h0,        32'h0};
        vecs[5]  = '{1'b0, 3'b011, 32'h100, 32'h0,        1'b1, 4'h0, 32'h0,        32'h0};
        vecs[6]  = '{1'b1, 3'b001, 32'h106, 32'hFFFF8001, 1'b0, 4'hC, 32'h80018001, 32'h0};
        vecs[7]  = '{1'b0, 3'b101, 32'h106, 32'h0,        1'b0, 4'hC, 32'h0,        32'h00008001};
        vecs[8]  = '{1'b0, 3'b001, 32'h106, 32'h0,        1'b0, 4'hC, 32'h0,        32'hFFFF8001};
        vecs[9]  = '{1'b1, 3'b000, 32'h104, 32'h12345680, 1'b0, 4'h1, 32'h80808080, 32'h0};
        vecs[10] = '{1'b0, 3'b100, 32'h104, 32'h0,        1'b0, 4'h1, 32'h0,        32'h00000080};
        vecs[11] = '{1'b0, 3'b000, 32'h104, 32'h0,        1'b0, 4'h1, 32'h0,        32'hFFFFFF80};
        vecs[12] = '{1'b1, 3'b000, 32'h100, 32'hFFFFFFAA, 1'b0, 4'h1, 32'hAAAAAAAA, 32'h0};
        vecs[13] = '{1'b0, 3'b010, 32'h100, 32'h0,        1'b0, 4'hF, 32'h0,        32'h123456AA};
        vecs[14] = '{1'b0, 3'b100, 32'h103, 32'h0,        1'b0, 4'h8, 32'h0,        32'h00000012};
        vecs[15] = '{1'b0, 3'b101, 32'h100, 32'h0,        1'b0, 4'h3, 32'h0,        32'h000056AA};
        vecs[16] = '{1'b0, 3'b001, 32'h101, 32'h0,        1'b1, 4'h0, 32'h0,        32'h0};
        vecs[17] = '{1'b1, 3'b010, 32'h101, 32'h0,        1'b1, 4'h0, 32'h0,        32'h0};
        vecs[18] = '{1'b0, 3'b101, 32'h104, 32'h0,        1'b0, 4'h3, 32'h0,        32'h00000080};

        #1;
        chk("rst bus_req", bus_req, 0);
        chk("rst stall", stall, 0);
        chk("rst bus_addr", bus_addr, 0);
        chk("rst bus_be", bus_be, 0);
        chk("rst dout", mem_data_out, 0);
        @(negedge clk);
        resetn = 1'b1;
        cycle();

        for (int i = 0; i < 19; i++) do_txn(vecs[i], i);

        // Ack never arrives: 16 BUSY cycles, then a one-cycle bus_err in DONE.
        busy_run(32'h100, 0, n, st);
        chk("to busy_cycles", n, 16);
        chk("to stable", st, 1);
        chk("to bus_err", bus_err, 1);
        chk("to stall", stall, 0);
        chk("to dout", mem_data_out, 0);
        cycle();
        chk("to err_oneshot", bus_err, 0);

        // Ack on the timeout cycle: ack wins.
        busy_run(32'h100, 16, n, st);
        chk("tie busy_cycles", n, 16);
        chk("tie bus_err", bus_err, 0);
        chk("tie dout", mem_data_out, 32'h123456AA);
        cycle();

        // Delayed ack after 3 BUSY cycles.
        busy_run(32'h104, 3, n, st);
        chk("late busy_cycles", n, 3);
        chk("late stable", st, 1);
        chk("late dout", mem_data_out, 32'h80010080);
        cycle();

        // Reset during BUSY, then a stray ack after release.
        drive_req(1'b0, 3'b010, 32'h100, 32'd0);
        cycle();
        chk("rb busy_req", bus_req, 1);
        resetn = 1'b0;
        #1;
        chk("rb bus_req", bus_req, 0);
        chk("rb stall", stall, 0);
        chk("rb bus_addr", bus_addr, 0);
        chk("rb dout", mem_data_out, 0);
        req_valid = 1'b0;
        @(negedge clk);
        resetn  = 1'b1;
        bus_ack = 1'b1;
        bus_rdata = 32'hCAFEF00D;
        cycle();
        bus_ack = 1'b0;
        #1;
        chk("rb stray_req", bus_req, 0);
        chk("rb stray_stall", stall, 0);
        chk("rb stray_dout", mem_data_out, 0);
        chk("rb stray_err", bus_err, 0);
        @(negedge clk);
        do_txn(vecs[13], 99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
